// File: rtl/and_ary_seq.sv
// and_ary_seq
//   Sequenced wide XOR-AND reduction. Computes d0 = &(a ^ b) over WIDTH bits
//   by pushing one CHUNK-bit slice per cycle through a single XOR/AND tree,
//   LSB chunk first, and stopping at the first chunk that fails.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
//   valid && ready are both high. The source holds valid (and its data)
//   until that edge; ready may rise or fall freely and has no dependency on
//   valid.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE and not in reset)
//   a, b       operands, sampled only on the accepting edge
//   out_valid  result valid (DONE)
//   out_ready  consumer takes the result
//   d0         reduction result
//   cycles     number of chunks evaluated for this result (1..NCHUNK)
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module and_ary_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
   localparam int CW     = $clog2(NCHUNK) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             d0,
   output logic [CW-1:0]    cycles,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [IDX_W-1:0]   idx;
   logic               acc;
   logic [CW-1:0]      cnt;

   logic [CHUNK-1:0]   slice_x;
   logic               slice_ok;
   logic               last_chunk;
   logic               accept;

   // The operand registers shift right one chunk per BUSY cycle, so the
   // slice always looks at the low CHUNK bits; idx tracks which chunk that is.
   assign slice_x    = a_reg[CHUNK-1:0] ^ b_reg[CHUNK-1:0];
   assign slice_ok   = &slice_x;
   assign last_chunk = (idx == IDX_W'(NCHUNK - 1));
   assign accept     = (state == IDLE) && in_valid && !rst;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid) state_nx = BUSY;
         BUSY: if (!slice_ok || last_chunk) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode. in_ready is also gated by rst so a request presented
   // during reset is visibly refused.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
      dbg_state = state;
   end

   // Operand capture and per-cycle chunk shift
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= a;
         b_reg <= b;
      end else if (state == BUSY) begin
         a_reg <= a_reg >> CHUNK;
         b_reg <= b_reg >> CHUNK;
      end
   end

   // Chunk index, accumulator (which is d0) and chunk count
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         acc <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  idx <= '0;
                  acc <= 1'b1;
               end
            end
            BUSY: begin
               if (!slice_ok || last_chunk) begin
                  // Early exit or final chunk: freeze result for DONE.
                  acc <= slice_ok;
                  cnt <= CW'(idx) + CW'(1);
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign d0     = acc;
   assign cycles = cnt;

endmodule

// File: tb/tb_and_ary_seq.sv
// tb_and_ary_seq
//   Directed and randomized bench for and_ary_seq (WIDTH=64, CHUNK=8).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_and_ary_seq;

   localparam int WIDTH  = 64;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             d0;
   logic [3:0]       cycles;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;

   and_ary_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d0        (d0),
      .cycles    (cycles),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the result fails at the lowest bit position where a and b
   // agree; the chunk holding that bit is the last one evaluated.
   function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                 output logic md, output int mc);
      logic [63:0] x;
      x  = ma ^ mb;
      md = 1'b1;
      mc = NCHUNK;
      for (int p = 0; p < WIDTH; p++) begin
         if (!x[p]) begin
            md = 1'b0;
            mc = p / CHUNK + 1;
            break;
         end
      end
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // One complete transaction: accept, measure latency, optional
   // backpressure for 'hold' cycles, optional noise on in_valid/a/b while
   // the block is busy, then handshake and confirm return to idle.
   task automatic run_req(input logic [63:0] ra, input logic [63:0] rb,
                          input int hold, input bit noise);
      logic ed;
      int   ec;
      int   lat;
      bit   timed_out;
      model(ra, rb, ed, ec);
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      a         = ra;
      b         = rb;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = rnd64();
      b        = rnd64();
      lat       = 0;
      timed_out = 1'b1;
      for (int k = 0; k <= NCHUNK + 2; k++) begin
         @(negedge clk);
         if (out_valid) begin
            timed_out = 1'b0;
            break;
         end
         lat++;
         chk("busy_in_ready", 64'(in_ready), 64'd0);
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = rnd64();
            b        = rnd64();
         end
      end
      chk("result_timeout", 64'(timed_out), 64'd0);
      if (!timed_out) begin
         chk("latency", 64'(lat), 64'(ec));
         chk("d0", 64'(d0), 64'(ed));
         chk("cycles", 64'(cycles), 64'(ec));
         chk("done_in_ready", 64'(in_ready), 64'd0);
         for (int h = 0; h < hold; h++) begin
            if (noise) begin
               in_valid = 1'($urandom_range(0, 1));
               a        = rnd64();
               b        = rnd64();
            end
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_d0", 64'(d0), 64'(ed));
            chk("hold_cycles", 64'(cycles), 64'(ec));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_out_valid", 64'(out_valid), 64'd0);
      chk("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] ta;
      logic [63:0] tb;
      bit          seen;

      // Reset
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_d0", 64'(d0), 64'd0);
      chk("rst_cycles", 64'(cycles), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_release_in_ready", 64'(in_ready), 64'd1);

      // Full match, early exit at chunk 0, late failure at bit 42
      ta = 64'h0123456789ABCDEF;
      run_req(ta, ~ta, 0, 1'b0);
      run_req(64'd0, 64'd0, 0, 1'b0);
      tb = ~ta;
      tb[42] = ta[42];
      run_req(ta, tb, 0, 1'b0);

      // Backpressure for 5 cycles on the full match
      run_req(ta, ~ta, 5, 1'b0);

      // Ignore while busy: noise on in_valid/a/b during BUSY and DONE
      run_req(ta, ~ta, 3, 1'b1);
      run_req(ta, tb, 2, 1'b1);

      // Reset in BUSY at idx=3: the request must vanish
      @(negedge clk);
      a         = ta;
      b         = ~ta;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midop_state_busy", 64'(dbg_state), 64'd1);
      rst = 1'b1;
      #1;
      chk("midop_rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midop_post_in_ready", 64'(in_ready), 64'd1);
      chk("midop_post_d0", 64'(d0), 64'd0);
      chk("midop_post_cycles", 64'(cycles), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < NCHUNK + 2; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midop_no_result", 64'(seen), 64'd0);
      run_req('1, 64'd0, 0, 1'b0);

      // Reset together with in_valid in IDLE: not accepted
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 64'd0;
      b        = 64'd0;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (out_valid || dbg_state != 2'd0) seen = 1'b1;
      end
      chk("rst_vs_in_valid", 64'(seen), 64'd0);

      // Reset together with out_ready in DONE: result dropped
      @(negedge clk);
      a         = 64'd0;
      b         = 64'd0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("done_before_rst", 64'(out_valid), 64'd1);
      rst       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_done_out_valid", 64'(out_valid), 64'd0);
      chk("rst_done_d0", 64'(d0), 64'd0);
      chk("rst_done_cycles", 64'(cycles), 64'd0);
      chk("rst_done_in_ready", 64'(in_ready), 64'd1);

      // Randomized traffic biased towards near-complement operands
      for (int n = 0; n < 40; n++) begin
         int mode;
         mode = $urandom_range(0, 3);
         ta   = rnd64();
         case (mode)
            0: tb = rnd64();
            1: tb = ~ta;
            default: begin
               tb = ~ta;
               tb[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
            end
         endcase
         run_req(ta, tb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
